robot_measure_sequencer: RTL

Sequences repeated duty-cycle measurement windows on the light sensor input and maps each result to a motor command. It generates a one-cycle sample tick, counts high and low samples over a fixed window, and computes `DutyPercent = floor(high*100/total)` with an iterative divider. It then thresholds the result onto `MotorSignal`. It sits between the raw `LightSignal` pin and the motor drivers, replacing free-running counters and a derived clock with one scheduled, single-clock controller.

---
 rtl/robot_measure_sequencer_if.sv | 29 ++
 rtl/robot_measure_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/robot_measure_sequencer_if.sv
// Handshake bundle between the light-sensor sequencer and its environment.
// master: the side that drives Enable/LightSignal (system controller / sensor pin).
// slave:  the sequencer itself, producing the motor command and duty result.
interface robot_measure_sequencer_if;
  logic       Enable;
  logic       LightSignal;
  logic [1:0] MotorSignal;
  logic [7:0] DutyPercent;
  logic       DutyValid;
  logic       Busy;

  modport master (
    output Enable,
    output LightSignal,
    input  MotorSignal,
    input  DutyPercent,
    input  DutyValid,
    input  Busy
  );

  modport slave (
    input  Enable,
    input  LightSignal,
    output MotorSignal,
    output DutyPercent,
    output DutyValid,
    output Busy
  );
endinterface

// File: rtl/robot_measure_sequencer.sv
// robot_measure_sequencer
// Repeated duty-cycle measurement of the synchronized light sensor input,
// followed by an iterative divide and a threshold decision onto MotorSignal.
// Optional build macro: ROBOT_HYSTERESIS_EN -- a changed motor command is only
// applied after two consecutive completed windows agree on it.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for Enable; Busy low
// CLEAR   | one cycle, zero sample counters and prescaler
// MEASURE | count high/low samples on each tick until the window is full
// DIVIDE  | 15-cycle restoring divide of high_cnt*100 by WINDOW_TICKS
// DECIDE  | one cycle, commit duty, pulse DutyValid, update MotorSignal
module robot_measure_sequencer #(
  parameter int TICK_DIV     = 2500,
  parameter int WINDOW_TICKS = 100,
  parameter int THRESH_LO    = 30,
  parameter int THRESH_HI    = 70
) (
  input  logic                      InputClock,
  input  logic                      Reset,
  robot_measure_sequencer_if.slave  bus
);

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  WIN_LAST   = 8'(WINDOW_TICKS - 1);
  localparam logic [8:0]  DIV_W      = 9'(WINDOW_TICKS);
  localparam logic [7:0]  T_LO       = 8'(THRESH_LO);
  localparam logic [7:0]  T_HI       = 8'(THRESH_HI);
  localparam logic [3:0]  DIV_LAST   = 4'd14;

  localparam logic [1:0] CMD_STOP    = 2'b00;
  localparam logic [1:0] CMD_SEARCH  = 2'b01;
  localparam logic [1:0] CMD_FORWARD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MEASURE,
    DIVIDE,
    DECIDE
  } state_t;

  state_t      state, state_nxt;

  logic        light_meta, light_sync;
  logic [15:0] presc_cnt;
  logic        tick;
  logic [7:0]  high_cnt, low_cnt, tick_cnt;
  logic [7:0]  high_fin;
  logic [14:0] num_load;

  logic [14:0] div_sr;
  logic [7:0]  div_rem;
  logic [3:0]  div_cnt;
  logic [8:0]  trial;
  logic [8:0]  trial_sub;
  logic        trial_ge;

  logic [7:0]  duty_q;
  logic [1:0]  new_cmd;
  logic        apply_cmd;

  logic        start_win, abort_win, commit, load_div;

  logic [1:0]  motor_q;
  logic [7:0]  duty_out_q;
  logic        valid_q;

  // Two-flop synchronizer for the asynchronous sensor pin.
  always_ff @(posedge InputClock or posedge Reset) begin
    if (Reset) begin
      light_meta <= 1'b0;
      light_sync <= 1'b0;
    end else begin
      light_meta <= bus.LightSignal;
      light_sync <= light_meta;
    end
  end

  // Sample-tick prescaler; only runs while measuring so every window starts aligned.
  always_ff @(posedge InputClock or posedge Reset) begin
    if (Reset) begin
      presc_cnt <= '0;
    end else if (state == MEASURE) begin
      if (presc_cnt == PRESC_LAST) presc_cnt <= '0;
      else                         presc_cnt <= presc_cnt + 16'd1;
    end else begin
      presc_cnt <= '0;
    end
  end

  assign tick = (state == MEASURE) && (presc_cnt == PRESC_LAST);

  // Final high count including the sample taken on the window's last tick.
  assign high_fin = high_cnt + {7'd0, light_sync};
  assign num_load = 15'(high_fin) * 15'd100;

  // FSM state register.
  always_ff @(posedge InputClock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state and control strobes; Enable low aborts any active phase before DECIDE.
  always_comb begin
    state_nxt = state;
    start_win = 1'b0;
    abort_win = 1'b0;
    commit    = 1'b0;
    load_div  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Enable) begin
          state_nxt = CLEAR;
          start_win = 1'b1;
        end
      end
      CLEAR: begin
        if (!bus.Enable) begin
          state_nxt = IDLE;
          abort_win = 1'b1;
        end else begin
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (!bus.Enable) begin
          state_nxt = IDLE;
          abort_win = 1'b1;
        end else if (tick && (tick_cnt == WIN_LAST)) begin
          state_nxt = DIVIDE;
          load_div  = 1'b1;
        end
      end
      DIVIDE: begin
        if (!bus.Enable) begin
          state_nxt = IDLE;
          abort_win = 1'b1;
        end else if (div_cnt == DIV_LAST) begin
          state_nxt = DECIDE;
        end
      end
      DECIDE: begin
        commit    = 1'b1;
        state_nxt = bus.Enable ? CLEAR : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sample counters: cleared at window start, advanced on each tick.
  always_ff @(posedge InputClock or posedge Reset) begin
    if (Reset) begin
      high_cnt <= '0;
      low_cnt  <= '0;
      tick_cnt <= '0;
    end else if (state == CLEAR) begin
      high_cnt <= '0;
      low_cnt  <= '0;
      tick_cnt <= '0;
    end else if (tick) begin
      if (light_sync) high_cnt <= high_cnt + 8'd1;
      else            low_cnt  <= low_cnt + 8'd1;
      tick_cnt <= tick_cnt + 8'd1;
    end
  end

  // One restoring-division step: shift in the next numerator bit, subtract if it fits.
  assign trial     = {div_rem, div_sr[14]};
  assign trial_ge  = (trial >= DIV_W);
  assign trial_sub = trial - DIV_W;

  // Divider datapath; the quotient accumulates in the numerator shift register.
  always_ff @(posedge InputClock or posedge Reset) begin
    if (Reset) begin
      div_sr  <= '0;
      div_rem <= '0;
      div_cnt <= '0;
    end else if (load_div) begin
      div_sr  <= num_load;
      div_rem <= '0;
      div_cnt <= '0;
    end else if (state == DIVIDE) begin
      div_sr  <= {div_sr[13:0], trial_ge};
      div_rem <= trial_ge ? trial_sub[7:0] : trial[7:0];
      div_cnt <= div_cnt + 4'd1;
    end
  end

  // Quotient never exceeds 100, so the low byte is the full duty value.
  assign duty_q = div_sr[7:0];

  // Threshold decision for the freshly computed duty.
  always_comb begin
    new_cmd = CMD_SEARCH;
    if (duty_q < T_LO)       new_cmd = CMD_STOP;
    else if (duty_q >= T_HI) new_cmd = CMD_FORWARD;
  end

`ifdef ROBOT_HYSTERESIS_EN
  logic [1:0] pend_cmd;
  logic       pend_vld;

  // Remember the previous completed window's command; forgotten on reset or abort.
  always_ff @(posedge InputClock or posedge Reset) begin
    if (Reset) begin
      pend_cmd <= CMD_STOP;
      pend_vld <= 1'b0;
    end else if (abort_win) begin
      pend_cmd <= CMD_STOP;
      pend_vld <= 1'b0;
    end else if (commit) begin
      pend_cmd <= new_cmd;
      pend_vld <= 1'b1;
    end
  end

  // With no history yet the first result is taken directly.
  assign apply_cmd = !pend_vld || (pend_cmd == new_cmd);
`else
  assign apply_cmd = 1'b1;
`endif

  // Result registers: duty, valid pulse and motor command all change on DECIDE exit.
  always_ff @(posedge InputClock or posedge Reset) begin
    if (Reset) begin
      motor_q    <= CMD_STOP;
      duty_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start_win || abort_win) begin
        motor_q <= CMD_STOP;
      end else if (commit) begin
        duty_out_q <= duty_q;
        valid_q    <= 1'b1;
        if (apply_cmd) motor_q <= new_cmd;
      end
    end
  end

  assign bus.MotorSignal = motor_q;
  assign bus.DutyPercent = duty_out_q;
  assign bus.DutyValid   = valid_q;
  assign bus.Busy        = (state != IDLE);

endmodule
